// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data-memory port between the CPU memory stage and a
//   DMA/loader master. The CPU has fixed priority. Two mechanisms guarantee
//   that the DMA master makes progress:
//     - a wait counter that forces a DMA win after MAX_WAIT lost cycles;
//     - a burst lock that keeps DMA ownership for up to MAX_BURST beats.
//   The CPU pipeline is stalled whenever it requests and loses arbitration.
//   DataMemory has a 1-cycle registered read latency. The read owner is
//   tracked so that returning data is steered to the master that issued it.
//
// Ports
//   i_clk, i_reset_n              clock, asynchronous active-low reset
//   i_cpu_req/we/addr/wdata       CPU access request
//   o_cpu_stall                   CPU request pending and not granted
//   o_cpu_rvalid, o_cpu_rdata     CPU read return (1 cycle after grant)
//   i_dma_req/we/addr/wdata       DMA access request
//   i_dma_lock                    DMA asks to keep ownership for next beat
//   o_dma_gnt                     DMA access accepted at the coming edge
//   o_dma_rvalid, o_dma_rdata     DMA read return (1 cycle after grant)
//   o_mem_en/we/addr/wdata        muxed memory request
//   i_mem_rdata                   memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DBITS     = 32,
    parameter int ABITS     = 32,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cpu_req,
    input  logic             i_cpu_we,
    input  logic [ABITS-1:0] i_cpu_addr,
    input  logic [DBITS-1:0] i_cpu_wdata,
    output logic             o_cpu_stall,
    output logic             o_cpu_rvalid,
    output logic [DBITS-1:0] o_cpu_rdata,
    input  logic             i_dma_req,
    input  logic             i_dma_we,
    input  logic [ABITS-1:0] i_dma_addr,
    input  logic [DBITS-1:0] i_dma_wdata,
    input  logic             i_dma_lock,
    output logic             o_dma_gnt,
    output logic             o_dma_rvalid,
    output logic [DBITS-1:0] o_dma_rdata,
    output logic             o_mem_en,
    output logic             o_mem_we,
    output logic [ABITS-1:0] o_mem_addr,
    output logic [DBITS-1:0] o_mem_wdata,
    input  logic [DBITS-1:0] i_mem_rdata
);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_CPU,
        RD_DMA
    } rd_owner_t;

    localparam logic [3:0] LP_MAX_WAIT  = 4'(MAX_WAIT);
    localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

    state_t    r_st;
    state_t    w_st_next;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_cnt_next;
    logic [3:0] r_burst_cnt;
    logic [3:0] w_burst_cnt_next;
    rd_owner_t r_rd_owner;
    rd_owner_t w_rd_owner_next;

    logic w_dma_win;
    logic w_cpu_win;

    // Winner selection. Reset is folded in so that nothing reaches memory
    // while reset is held, even though the state registers are already idle.
    always_comb begin
        w_dma_win = i_reset_n & i_dma_req &
                    ((r_st == ST_BURST) | ~i_cpu_req | (r_wait_cnt == LP_MAX_WAIT));
        w_cpu_win = i_reset_n & i_cpu_req & ~w_dma_win;
    end

    // Next-state logic for the burst FSM, the counters and the read owner.
    always_comb begin
        w_st_next        = r_st;
        w_burst_cnt_next = r_burst_cnt;
        w_wait_cnt_next  = r_wait_cnt;
        w_rd_owner_next  = RD_NONE;

        case (r_st)
            ST_IDLE: begin
                w_burst_cnt_next = 4'd0;
                // With MAX_BURST==1 the single locked beat is already the
                // whole burst, so the FSM never leaves IDLE.
                if (w_dma_win && i_dma_lock && (LP_MAX_BURST > 4'd1)) begin
                    w_st_next        = ST_BURST;
                    w_burst_cnt_next = 4'd1;
                end
            end
            ST_BURST: begin
                if (!w_dma_win) begin
                    w_st_next        = ST_IDLE;
                    w_burst_cnt_next = 4'd0;
                end else if (!i_dma_lock || (r_burst_cnt + 4'd1 == LP_MAX_BURST)) begin
                    // This beat is the last one; CPU gets priority next cycle.
                    w_st_next        = ST_IDLE;
                    w_burst_cnt_next = 4'd0;
                end else begin
                    w_burst_cnt_next = r_burst_cnt + 4'd1;
                end
            end
            default: begin
                w_st_next        = ST_IDLE;
                w_burst_cnt_next = 4'd0;
            end
        endcase

        if (i_dma_req && !w_dma_win) begin
            if (r_wait_cnt != LP_MAX_WAIT) begin
                w_wait_cnt_next = r_wait_cnt + 4'd1;
            end
        end else begin
            w_wait_cnt_next = 4'd0;
        end

        if (w_cpu_win && !i_cpu_we) begin
            w_rd_owner_next = RD_CPU;
        end else if (w_dma_win && !i_dma_we) begin
            w_rd_owner_next = RD_DMA;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_st        <= ST_IDLE;
            r_wait_cnt  <= 4'd0;
            r_burst_cnt <= 4'd0;
            r_rd_owner  <= RD_NONE;
        end else begin
            r_st        <= w_st_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_burst_cnt <= w_burst_cnt_next;
            r_rd_owner  <= w_rd_owner_next;
        end
    end

    // Memory request mux and master-side outputs.
    always_comb begin
        o_mem_en    = w_cpu_win | w_dma_win;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_dma_win) begin
            o_mem_we    = i_dma_we;
            o_mem_addr  = i_dma_addr;
            o_mem_wdata = i_dma_wdata;
        end else if (w_cpu_win) begin
            o_mem_we    = i_cpu_we;
            o_mem_addr  = i_cpu_addr;
            o_mem_wdata = i_cpu_wdata;
        end

        o_cpu_stall  = i_cpu_req & ~w_cpu_win;
        o_dma_gnt    = w_dma_win;
        o_cpu_rvalid = (r_rd_owner == RD_CPU);
        o_dma_rvalid = (r_rd_owner == RD_DMA);
        o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
        o_dma_rdata  = o_dma_rvalid ? i_mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Bench for dmem_arbiter. A small data memory with registered read stands in
//   for DataMemory. A behavioural model (lost-cycle count, beats taken in the
//   current burst, pending read return, shadow memory) predicts every output.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DBITS     = 32;
    localparam int ABITS     = 32;
    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [ABITS-1:0] cpu_addr, dma_addr;
    logic [DBITS-1:0] cpu_wdata, dma_wdata;
    logic             cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DBITS-1:0] cpu_rdata, dma_rdata;
    logic             mem_en, mem_we;
    logic [ABITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DBITS(DBITS), .ABITS(ABITS), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_stall(cpu_stall),
        .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr),
        .i_dma_wdata(dma_wdata), .i_dma_lock(dma_lock), .o_dma_gnt(dma_gnt),
        .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // ---------------- memory stand-in ----------------
    function automatic logic [31:0] init_word(input int idx);
        if (idx == 64) return 32'hDEAD_BEEF;   // byte address 0x100
        return 32'hA5A5_0000 ^ (32'(idx) * 32'h9E37_79B9);
    endfunction

    logic [31:0] env_mem [0:1023];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) env_mem[mem_addr[11:2]] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr[11:2]];
        end
    end

    // ---------------- behavioural model ----------------
    logic [31:0] ref_mem [0:1023];
    bit          m_burst;     // DMA holds a lock on the port
    int          m_beats;     // beats granted in the current burst
    int          m_lost;      // consecutive cycles the DMA request was refused
    int          m_rd_who;    // 0 none, 1 cpu, 2 dma : read data returning now
    logic [31:0] m_rd_data;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic bit exp_dma_win();
        if (!rst_n || !dma_req) return 1'b0;
        if (m_burst || !cpu_req) return 1'b1;
        return m_lost >= MAX_WAIT;
    endfunction

    function automatic bit exp_cpu_win();
        return rst_n && cpu_req && !exp_dma_win();
    endfunction

    task automatic model_reset();
        m_burst = 0; m_beats = 0; m_lost = 0; m_rd_who = 0; m_rd_data = '0;
    endtask

    task automatic drive(input bit cr, input bit cw, input logic [31:0] ca,
                         input logic [31:0] cd, input bit dr, input bit dw,
                         input logic [31:0] da, input logic [31:0] dd, input bit dl);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = dl;
    endtask

    // Applies the current cycle to the model, then moves to just after the edge.
    task automatic advance();
        bit dwin, cwin;
        dwin = exp_dma_win();
        cwin = exp_cpu_win();
        if (rst_n) begin
            m_rd_who = 0;
            if (cwin) begin
                if (cpu_we) ref_mem[cpu_addr[11:2]] = cpu_wdata;
                else begin m_rd_who = 1; m_rd_data = ref_mem[cpu_addr[11:2]]; end
            end else if (dwin) begin
                if (dma_we) ref_mem[dma_addr[11:2]] = dma_wdata;
                else begin m_rd_who = 2; m_rd_data = ref_mem[dma_addr[11:2]]; end
            end
            if (dma_req && !dwin) m_lost = (m_lost < MAX_WAIT) ? m_lost + 1 : MAX_WAIT;
            else                  m_lost = 0;
            if (dwin) begin
                m_beats = m_burst ? m_beats + 1 : 1;
                m_burst = dma_lock && (m_beats < MAX_BURST);
            end else begin
                m_burst = 0;
            end
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
        advance();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1, 0, 32'h40, '0, 1, 0, 32'h80, '0, 1);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({mem_en, dma_gnt, cpu_stall} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_arb {mem_en,gnt,stall}=%b want 001", {mem_en, dma_gnt, cpu_stall});
        end
        n_tests++;
        if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_rd rv=%b%b cpu_rdata=%h dma_rdata=%h want 0", cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
        end
        rst_n = 1'b1;
        model_reset();
        idle_cycle();
    endtask

    task automatic test_cpu_read();
        drive(1, 0, 32'h100, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        n_tests++;
        if ({mem_en, cpu_stall, mem_we} !== 3'b100 || mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL cpu_read_req en/stall/we=%b addr=%h want 100/00000100", {mem_en, cpu_stall, mem_we}, mem_addr);
        end
        advance();
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        n_tests++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL cpu_read_data rvalid=%b rdata=%h want 1/deadbeef", cpu_rvalid, cpu_rdata);
        end
        advance();
    endtask

    // CPU wins 4 cycles, DMA takes the 5th, repeating.
    task automatic test_fair_share();
        idle_cycle();
        for (int i = 0; i < 15; i++) begin
            drive(1, 0, 32'h10, '0, 1, 0, 32'h20, '0, 0);
            @(negedge clk);
            n_tests++;
            if (dma_gnt !== (i % 5 == 4) || cpu_stall !== (i % 5 == 4)) begin
                n_fail++;
                $display("FAIL fair_share cyc=%0d gnt=%b stall=%b want %b", i, dma_gnt, cpu_stall, (i % 5 == 4));
            end
            advance();
        end
    endtask

    // Locked burst: 4 CPU, 8 DMA beats, CPU again until DMA waits MAX_WAIT.
    task automatic test_burst_max();
        bit want;
        idle_cycle();
        for (int i = 0; i < 18; i++) begin
            drive(1, 0, 32'h30, '0, 1, 0, 32'h34, '0, 1);
            want = (i >= 4 && i <= 11) || (i >= 16);
            @(negedge clk);
            n_tests++;
            if (dma_gnt !== want || cpu_stall !== want) begin
                n_fail++;
                $display("FAIL burst_max cyc=%0d gnt=%b stall=%b want %b", i, dma_gnt, cpu_stall, want);
            end
            advance();
        end
    endtask

    // Lock drops on the 3rd beat: burst ends, CPU wins and waiting restarts.
    task automatic test_lock_drop();
        bit want;
        idle_cycle();
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 32'h50, '0, 1, 0, 32'h54, '0, i < 6);
            want = (i >= 4 && i <= 6) || (i == 11);
            @(negedge clk);
            n_tests++;
            if (dma_gnt !== want) begin
                n_fail++;
                $display("FAIL lock_drop cyc=%0d gnt=%b want %b", i, dma_gnt, want);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_burst();
        idle_cycle();
        drive(0, 0, '0, '0, 1, 0, 32'h88, '0, 1);
        advance();
        advance();
        n_tests++;
        if (dma_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_burst_inflight dma_rvalid=%b want 1", dma_rvalid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({dma_rvalid, cpu_rvalid, mem_en, dma_gnt} !== 4'b0000 || dma_rdata !== '0) begin
            n_fail++;
            $display("FAIL mid_burst_reset rv/en/gnt=%b dma_rdata=%h want 0000/0", {dma_rvalid, cpu_rvalid, mem_en, dma_gnt}, dma_rdata);
        end
        model_reset();
        drive(1, 0, 32'h40, '0, 1, 0, 32'h88, '0, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL post_reset_cpu gnt=%b stall=%b addr=%h want 0/0/00000040", dma_gnt, cpu_stall, mem_addr);
        end
        advance();
    endtask

    task automatic test_dma_write_cpu_read();
        idle_cycle();
        drive(0, 0, '0, '0, 1, 1, 32'h200, 32'h1234_5678, 0);
        @(negedge clk);
        n_tests++;
        if ({dma_gnt, mem_we} !== 2'b11 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL dma_write gnt/we=%b addr=%h wdata=%h want 11/200/12345678", {dma_gnt, mem_we}, mem_addr, mem_wdata);
        end
        advance();
        drive(1, 0, 32'h200, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        n_tests++;
        if (dma_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL dma_write_rvalid dma_rvalid=%b want 0", dma_rvalid);
        end
        advance();
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        n_tests++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234_5678 || dma_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_readback rvalid=%b rdata=%h dma_rvalid=%b want 1/12345678/0", cpu_rvalid, cpu_rdata, dma_rvalid);
        end
        advance();
    endtask

    task automatic test_random();
        bit dwin, cwin;
        logic [31:0] e_addr, e_wdata;
        bit e_we;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                  {20'd0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom,
                  $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                  {20'd0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom,
                  $urandom_range(0, 99) < 70);
            dwin = exp_dma_win();
            cwin = exp_cpu_win();
            e_we = dwin ? dma_we : (cwin ? cpu_we : 1'b0);
            e_addr = dwin ? dma_addr : (cwin ? cpu_addr : '0);
            e_wdata = dwin ? dma_wdata : (cwin ? cpu_wdata : '0);
            @(negedge clk);
            n_tests++;
            if ({dma_gnt, cpu_stall, mem_en, mem_we} !== {dwin, cpu_req && !cwin, dwin || cwin, e_we}) begin
                n_fail++;
                $display("FAIL rand_arb cyc=%0d {gnt,stall,en,we}=%b want %b", i,
                         {dma_gnt, cpu_stall, mem_en, mem_we}, {dwin, cpu_req && !cwin, dwin || cwin, e_we});
            end
            n_tests++;
            if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                n_fail++;
                $display("FAIL rand_mux cyc=%0d addr=%h wdata=%h want %h/%h", i, mem_addr, mem_wdata, e_addr, e_wdata);
            end
            n_tests++;
            if (cpu_rvalid !== (m_rd_who == 1) || dma_rvalid !== (m_rd_who == 2) ||
                cpu_rdata !== ((m_rd_who == 1) ? m_rd_data : 32'd0) ||
                dma_rdata !== ((m_rd_who == 2) ? m_rd_data : 32'd0)) begin
                n_fail++;
                $display("FAIL rand_rd cyc=%0d rv=%b%b cpu=%h dma=%h want owner=%0d data=%h", i,
                         cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, m_rd_who, m_rd_data);
            end
            advance();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        preload = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        model_reset();
        @(posedge clk);
        #1;
        preload = 1'b0;
        test_reset();
        test_cpu_read();
        test_fair_share();
        test_burst_max();
        test_lock_drop();
        test_reset_mid_burst();
        test_dma_write_cpu_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
